reg_stage_arbiter: RTL and testbench

REG_STAGE_ARBITER -- requirements
Module: reg_stage_arbiter

---
 rtl/reg_stage_arbiter.sv | 110 +++++++++++
 tb/tb_reg_stage_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_stage_arbiter.sv
// Round-robin arbiter feeding a single-entry register stage; grant_cnt port exists only with REG_STAGE_ARB_GRANT_CNT_EN.
// Latency: 1 cycle from req_valid/req_ready transfer to out_valid/out_data.
// Backpressure: req_ready is held low while the stage is full and out_ready is low, giving 1 word/cycle when not stalled.
module reg_stage_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
`ifdef REG_STAGE_ARB_GRANT_CNT_EN
  ,
  output logic [NREQ*16-1:0]        grant_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   pick;
  logic             found;
  logic             accept;
  logic             xfer;
  int unsigned      cand;

  // Search starts one past the last winner so every valid requester is reached within NREQ grants.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = IDW'(cand);
      end
    end
  end

  assign accept    = !reset && ((state_q == EMPTY) || out_ready);
  assign req_ready = (accept && found) ? (NREQ'(1) << pick) : '0;
  assign xfer      = accept && found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (out_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      grant_id   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else if (xfer) begin
      out_data   <= req_data[pick*WIDTH +: WIDTH];
      grant_id   <= pick;
      last_grant <= pick;
    end
  end

  assign out_valid = (state_q == FULL);
  assign busy      = out_valid;

`ifdef REG_STAGE_ARB_GRANT_CNT_EN
  logic [15:0] cnt_q [NREQ];

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (xfer) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pick == IDW'(i) && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_reg_stage_arbiter.sv
// Directed vector bench for reg_stage_arbiter (WIDTH=8, NREQ=4).
module tb_reg_stage_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef REG_STAGE_ARB_GRANT_CNT_EN
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_stage_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef REG_STAGE_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        ordy;
    logic [3:0]  rr;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  gid;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    // inputs: rv, rd, out_ready | expected: req_ready, then after edge out_valid, out_data, grant_id
    vecs[0]  = '{4'b0001, 32'hD3D2D1A5, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0};
    vecs[1]  = '{4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[2]  = '{4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[3]  = '{4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[4]  = '{4'b1001, 32'h23222120, 1'b1, 4'b0001, 1'b1, 8'h20, 2'd0};
    vecs[5]  = '{4'b1001, 32'h23222120, 1'b1, 4'b1000, 1'b1, 8'h23, 2'd3};
    vecs[6]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h23, 2'd3};
    vecs[7]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h23, 2'd3};
    vecs[8]  = '{4'b0001, 32'h3332313C, 1'b0, 4'b0001, 1'b1, 8'h3C, 2'd0};
    vecs[9]  = '{4'b1110, 32'h43424140, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    vecs[10] = '{4'b1110, 32'h43424140, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    vecs[11] = '{4'b1110, 32'h43424140, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    vecs[12] = '{4'b1110, 32'h43424140, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    vecs[13] = '{4'b1110, 32'h43424140, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    vecs[14] = '{4'b1110, 32'h43424140, 1'b1, 4'b0010, 1'b1, 8'h41, 2'd1};
    vecs[15] = '{4'b0000, 32'h53525150, 1'b0, 4'b0000, 1'b1, 8'h41, 2'd1};
    vecs[16] = '{4'b0010, 32'h63626160, 1'b0, 4'b0000, 1'b1, 8'h41, 2'd1};
    vecs[17] = '{4'b0000, 32'h63626160, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd1};

    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    out_ready = 1'b1;
    #1;
    chk("rst rr", 64'(req_ready), 64'h0);
    chk("rst ov", 64'(out_valid), 64'h0);
    chk("rst od", 64'(out_data), 64'h0);
    chk("rst gid", 64'(grant_id), 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold ov", 64'(out_valid), 64'h0);
    @(negedge clk);
    req_valid = 4'b0000;
    reset     = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req_valid = vecs[i].rv;
      req_data  = vecs[i].rd;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d rr", i), 64'(req_ready), 64'(vecs[i].rr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ov", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("v%0d od", i), 64'(out_data), 64'(vecs[i].od));
      chk($sformatf("v%0d gid", i), 64'(grant_id), 64'(vecs[i].gid));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].ov));
    end

    // Fill the stage, then hit reset between edges.
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = 32'h00770000;
    out_ready = 1'b0;
    #1;
    chk("mid rr", 64'(req_ready), 64'h4);
    @(posedge clk);
    #1;
    chk("mid ov", 64'(out_valid), 64'h1);
    chk("mid od", 64'(out_data), 64'h77);
    chk("mid gid", 64'(grant_id), 64'h2);
    #2;
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    out_ready = 1'b1;
    #1;
    chk("arst ov", 64'(out_valid), 64'h0);
    chk("arst od", 64'(out_data), 64'h0);
    chk("arst gid", 64'(grant_id), 64'h0);
    chk("arst busy", 64'(busy), 64'h0);
    chk("arst rr", 64'(req_ready), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post rr", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("post gid", 64'(grant_id), 64'h0);
    chk("post od", 64'(out_data), 64'h11);
    chk("post ov", 64'(out_valid), 64'h1);

`ifdef REG_STAGE_ARB_GRANT_CNT_EN
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    chk("cnt rst", 64'(grant_cnt), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("cnt2 sat", 64'(grant_cnt[47:32]), 64'hFFFF);
    chk("cnt others", {grant_cnt[63:48], grant_cnt[31:0]}, 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
